// File: rtl/music_pkg.sv
// Shared types and score-entry layout for the beat-level music sequencer.
// A score entry is {end_flag, dur, note}; a note code of zero is a rest.
package music_pkg;

  localparam int OFS_W_DEF     = 6;
  localparam int SONG_W_DEF    = 2;
  localparam int NUM_SONGS_DEF = 4;
  localparam int NOTE_W_DEF    = 12;
  localparam int DUR_W_DEF     = 3;

  localparam int DUR_LSB = NOTE_W_DEF;
  localparam int END_BIT = NOTE_W_DEF + DUR_W_DEF;
  localparam int ENTRY_W = END_BIT + 1;

  localparam logic [NOTE_W_DEF-1:0] REST_CODE = '0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAYING = 2'd1,
    ST_PAUSED  = 2'd2
  } state_e;

  function automatic logic [ENTRY_W-1:0] mk_entry(input logic end_flag,
                                                  input logic [DUR_W_DEF-1:0] dur,
                                                  input logic [NOTE_W_DEF-1:0] note);
    logic [ENTRY_W-1:0] e;
    e = '0;
    e[END_BIT]                   = end_flag;
    e[DUR_LSB +: DUR_W_DEF]      = dur;
    e[NOTE_W_DEF-1:0]            = note;
    return e;
  endfunction

endpackage

// File: rtl/music_score_rom.sv
// Combinational score ROM holding all songs; address is {song_idx, offset}.
// Any address without an explicit entry reads back as an end marker.
module music_score_rom
  import music_pkg::*;
(
  input  logic [SONG_W_DEF+OFS_W_DEF-1:0] addr_i,
  output logic [ENTRY_W-1:0]              data_o
);

  // Note codes are {high, med, low} nibbles, pitch 1..7 = C..B within an octave.
  localparam logic [NOTE_W_DEF-1:0] N_C4 = 12'h010;
  localparam logic [NOTE_W_DEF-1:0] N_D4 = 12'h020;
  localparam logic [NOTE_W_DEF-1:0] N_E4 = 12'h030;
  localparam logic [NOTE_W_DEF-1:0] N_F4 = 12'h040;
  localparam logic [NOTE_W_DEF-1:0] N_G4 = 12'h050;
  localparam logic [NOTE_W_DEF-1:0] N_A4 = 12'h060;
  localparam logic [NOTE_W_DEF-1:0] N_C5 = 12'h100;

  always_comb begin
    data_o = mk_entry(1'b1, 3'd0, REST_CODE);
    case (addr_i)
      // song 0: rising scale
      8'h00: data_o = mk_entry(1'b0, 3'd1, N_C4);
      8'h01: data_o = mk_entry(1'b0, 3'd1, N_D4);
      8'h02: data_o = mk_entry(1'b0, 3'd1, N_E4);
      8'h03: data_o = mk_entry(1'b0, 3'd1, N_F4);
      8'h04: data_o = mk_entry(1'b0, 3'd3, N_G4);
      8'h05: data_o = mk_entry(1'b0, 3'd3, N_G4);
      // song 1: twinkle fragment
      8'h40: data_o = mk_entry(1'b0, 3'd1, N_C4);
      8'h41: data_o = mk_entry(1'b0, 3'd1, N_C4);
      8'h42: data_o = mk_entry(1'b0, 3'd1, N_G4);
      8'h43: data_o = mk_entry(1'b0, 3'd1, N_G4);
      8'h44: data_o = mk_entry(1'b0, 3'd1, N_A4);
      8'h45: data_o = mk_entry(1'b0, 3'd1, N_A4);
      8'h46: data_o = mk_entry(1'b0, 3'd3, N_G4);
      8'h47: data_o = mk_entry(1'b0, 3'd0, REST_CODE);
      8'h48: data_o = mk_entry(1'b0, 3'd1, N_F4);
      8'h49: data_o = mk_entry(1'b0, 3'd1, N_F4);
      8'h4A: data_o = mk_entry(1'b0, 3'd1, N_E4);
      8'h4B: data_o = mk_entry(1'b0, 3'd1, N_E4);
      8'h4C: data_o = mk_entry(1'b0, 3'd1, N_D4);
      8'h4D: data_o = mk_entry(1'b0, 3'd1, N_D4);
      8'h4E: data_o = mk_entry(1'b0, 3'd3, N_C4);
      // song 2: quick phrase
      8'h80: data_o = mk_entry(1'b0, 3'd0, N_E4);
      8'h81: data_o = mk_entry(1'b0, 3'd0, N_D4);
      8'h82: data_o = mk_entry(1'b0, 3'd0, N_C4);
      8'h83: data_o = mk_entry(1'b0, 3'd0, N_D4);
      8'h84: data_o = mk_entry(1'b0, 3'd0, N_E4);
      8'h85: data_o = mk_entry(1'b0, 3'd0, N_E4);
      8'h86: data_o = mk_entry(1'b0, 3'd1, N_E4);
      // song 3: descending chime
      8'hC0: data_o = mk_entry(1'b0, 3'd3, N_C5);
      8'hC1: data_o = mk_entry(1'b0, 3'd3, N_G4);
      8'hC2: data_o = mk_entry(1'b0, 3'd3, N_C4);
      default: data_o = mk_entry(1'b1, 3'd0, REST_CODE);
    endcase
  end

endmodule

// File: rtl/music_sequencer.sv
// Beat-level score sequencer: one beat per clk_4hz edge, per-note durations,
// song select, play/pause/stop/next and loop. The score ROM sits outside.
module music_sequencer
  import music_pkg::*;
#(
  parameter int OFS_W     = OFS_W_DEF,
  parameter int SONG_W    = SONG_W_DEF,
  parameter int NUM_SONGS = NUM_SONGS_DEF,
  parameter int NOTE_W    = NOTE_W_DEF,
  parameter int DUR_W     = DUR_W_DEF
) (
  input  logic                     clk_4hz,
  input  logic                     rst_n,
  input  logic                     play,
  input  logic                     pause,
  input  logic                     stop,
  input  logic                     next_song,
  input  logic                     loop_en,
  input  logic [SONG_W-1:0]        song_sel,
  output logic [SONG_W+OFS_W-1:0]  rom_addr,
  input  logic [NOTE_W+DUR_W:0]    rom_data,
  output logic [NOTE_W-1:0]        note_code,
  output logic                     note_valid,
  output logic [SONG_W-1:0]        song_idx,
  output logic                     busy,
  output logic                     done
);

  localparam int END_POS = NOTE_W + DUR_W;
  localparam logic [NOTE_W-1:0] REST = NOTE_W'(REST_CODE);

  state_e              state_q, state_d;
  // Extra top bit marks "past the last entry of the region".
  logic [OFS_W:0]      offset_q, offset_d;
  logic [DUR_W-1:0]    dur_q, dur_d;
  logic [SONG_W-1:0]   song_q, song_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic                vld_q, vld_d;
  logic                done_q, done_d;

  logic                ent_end;
  logic [DUR_W-1:0]    ent_dur;
  logic [NOTE_W-1:0]   ent_note;
  logic [SONG_W-1:0]   song_nxt;

  assign ent_end  = rom_data[END_POS] | offset_q[OFS_W];
  assign ent_dur  = rom_data[NOTE_W +: DUR_W];
  assign ent_note = rom_data[NOTE_W-1:0];

  always_comb begin
    if (32'(song_q) + 32'd1 == 32'(NUM_SONGS)) song_nxt = '0;
    else                                      song_nxt = song_q + 1'b1;
  end

  always_ff @(posedge clk_4hz or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      offset_q <= '0;
      dur_q    <= '0;
      song_q   <= '0;
      note_q   <= '0;
      vld_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      dur_q    <= dur_d;
      song_q   <= song_d;
      note_q   <= note_d;
      vld_q    <= vld_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    dur_d    = dur_q;
    song_d   = song_q;
    note_d   = note_q;
    vld_d    = vld_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (stop) begin
          note_d   = REST;
          vld_d    = 1'b0;
          offset_d = '0;
        end else if (play) begin
          song_d   = song_sel;
          offset_d = '0;
          dur_d    = '0;
          state_d  = ST_PLAYING;
        end
      end
      ST_PLAYING, ST_PAUSED: begin
        if (stop) begin
          state_d  = ST_IDLE;
          note_d   = REST;
          vld_d    = 1'b0;
          offset_d = '0;
          dur_d    = '0;
        end else if (next_song) begin
          song_d   = song_nxt;
          offset_d = '0;
          dur_d    = '0;
          vld_d    = 1'b0;
          state_d  = ST_PLAYING;
        end else if (state_q == ST_PAUSED) begin
          // pause outranks play, so both together keep the block paused
          if (!pause && play) begin
            state_d = ST_PLAYING;
            vld_d   = (note_q != REST);
          end
        end else if (pause) begin
          state_d = ST_PAUSED;
          vld_d   = 1'b0;
        end else if (dur_q != '0) begin
          dur_d = dur_q - 1'b1;
        end else if (!ent_end) begin
          note_d   = ent_note;
          vld_d    = (ent_note != REST);
          dur_d    = ent_dur;
          offset_d = offset_q + 1'b1;
        end else begin
          // end marker (or region exhausted) costs one silent beat
          note_d   = REST;
          vld_d    = 1'b0;
          offset_d = '0;
          if (!loop_en) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rom_addr   = {song_q, offset_q[OFS_W-1:0]};
  assign note_code  = note_q;
  assign note_valid = vld_q;
  assign song_idx   = song_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;

endmodule
